// File: rtl/decode_stage_pkg.sv
// RV32I shared definitions: opcodes, ALU/op-type encodings, ID/EX record.
package risc_v_32i;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ADD  = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
    XOR  = 4'd5, SRL = 4'd6, SRA = 4'd7, OR  = 4'd8, AND  = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    OPT_LUI    = 4'd0, OPT_AUIPC = 4'd1, OPT_JAL    = 4'd2,  OPT_JALR   = 4'd3,
    OPT_BRANCH = 4'd4, OPT_LOAD  = 4'd5, OPT_STORE  = 4'd6,  OPT_OP_IMM = 4'd7,
    OPT_OP     = 4'd8, OPT_FENCE = 4'd9, OPT_SYSTEM = 4'd10, OPT_ILLEGAL = 4'd11
  } op_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_t     alu_op;
    op_type_t    op_type;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } id_ex_t;

  // Register ops use the alt bit for SUB and SRA; immediate ops only for SRAI.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                         input logic alt, input logic is_reg);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? SUB : ADD;
      3'b001:  op = SLL;
      3'b010:  op = SLT;
      3'b011:  op = SLTU;
      3'b100:  op = XOR;
      3'b101:  op = alt ? SRA : SRL;
      3'b110:  op = OR;
      3'b111:  op = AND;
      default: op = ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX bus: decode (master) presents a registered instruction, execute (slave) accepts it.
interface decode_stage_if
  import risc_v_32i::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rd;
  logic [2:0]      ex_funct3;
  alu_op_t         ex_alu_op;
  op_type_t        ex_op_type;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_funct3,
           ex_alu_op, ex_op_type, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_funct3,
           ex_alu_op, ex_op_type, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from instr[31].
module imm_gen
  import risc_v_32i::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  // Pick the immediate format from the opcode.
  always_comb begin
    imm = {XLEN{1'b0}};
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile read, writeback bypass, load-use stall, ID/EX register.
module decode_stage
  import risc_v_32i::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_read,
  input  logic [XLEN-1:0] rs2_read,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  decode_stage_if.master  ex
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [RA_W-1:0] rd_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  op_type_t        op_type_s;
  alu_op_t         alu_op_s;
  logic            uses_rs1_s;
  logic            uses_rs2_s;
  logic            writes_rd_s;
  logic            reg_write_s;
  logic            mem_read_s;
  logic            mem_write_s;
  logic            illegal_s;
  logic            hazard_s;
  logic            load_en_s;
  id_ex_t          dec_s;
  id_ex_t          id_ex_r;
  logic            ex_valid_r;

  assign opcode_s = if_instr[6:0];
  assign funct3_s = if_instr[14:12];
  assign rd_s     = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm_s)
  );

  // Opcode decode: op type, ALU op, source usage and control flags.
  always_comb begin
    op_type_s   = OPT_ILLEGAL;
    alu_op_s    = ADD;
    uses_rs1_s  = 1'b1;
    uses_rs2_s  = 1'b0;
    writes_rd_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    case (opcode_s)
      OPC_LUI:    begin op_type_s = OPT_LUI;   uses_rs1_s = 1'b0; writes_rd_s = 1'b1; end
      OPC_AUIPC:  begin op_type_s = OPT_AUIPC; uses_rs1_s = 1'b0; writes_rd_s = 1'b1; end
      OPC_JAL:    begin op_type_s = OPT_JAL;   uses_rs1_s = 1'b0; writes_rd_s = 1'b1; end
      OPC_JALR:   begin op_type_s = OPT_JALR;  writes_rd_s = 1'b1; end
      OPC_BRANCH: begin op_type_s = OPT_BRANCH; uses_rs2_s = 1'b1; end
      OPC_LOAD:   begin op_type_s = OPT_LOAD;  writes_rd_s = 1'b1; mem_read_s = 1'b1; end
      OPC_STORE:  begin op_type_s = OPT_STORE; uses_rs2_s = 1'b1; mem_write_s = 1'b1; end
      OPC_OP_IMM: begin
        op_type_s   = OPT_OP_IMM;
        writes_rd_s = 1'b1;
        alu_op_s    = alu_decode(funct3_s, if_instr[30], 1'b0);
      end
      OPC_OP: begin
        op_type_s   = OPT_OP;
        uses_rs2_s  = 1'b1;
        writes_rd_s = 1'b1;
        alu_op_s    = alu_decode(funct3_s, if_instr[30], 1'b1);
      end
      OPC_FENCE:  op_type_s = OPT_FENCE;
      OPC_SYSTEM: op_type_s = OPT_SYSTEM;
      default:    illegal_s = 1'b1;
    endcase
    reg_write_s = writes_rd_s && (rd_s != {RA_W{1'b0}});
  end

  // Operand select: a same-cycle writeback to a nonzero source wins over the regfile.
  always_comb begin
    if (wb_we && (wb_addr == rs1_addr) && (wb_addr != {RA_W{1'b0}})) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = rs1_read;
    end
    if (wb_we && (wb_addr == rs2_addr) && (wb_addr != {RA_W{1'b0}})) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = rs2_read;
    end
  end

  // A load in ID/EX cannot feed a dependent instruction until it reaches writeback.
  assign hazard_s  = ex_valid_r && id_ex_r.mem_read && (id_ex_r.rd != 5'd0) &&
                     ((uses_rs1_s && (id_ex_r.rd == rs1_addr)) ||
                      (uses_rs2_s && (id_ex_r.rd == rs2_addr)));
  assign load_en_s = !ex_valid_r || ex.ex_ready;
  assign id_ready  = load_en_s && (!hazard_s || flush);

  assign dec_s = '{pc: if_pc, rs1_val: rs1_val_s, rs2_val: rs2_val_s, imm: imm_s,
                   rd: rd_s, funct3: funct3_s, alu_op: alu_op_s, op_type: op_type_s,
                   reg_write: reg_write_s && !illegal_s, mem_read: mem_read_s,
                   mem_write: mem_write_s, illegal: illegal_s};

  // ID/EX register: flush beats hazard bubble beats capture; holds while execute stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_r    <= '0;
      ex_valid_r <= 1'b0;
    end else if (load_en_s) begin
      if (flush) begin
        ex_valid_r <= 1'b0;
      end else if (hazard_s) begin
        ex_valid_r <= 1'b0;
      end else if (if_valid) begin
        id_ex_r    <= dec_s;
        ex_valid_r <= 1'b1;
      end else begin
        ex_valid_r <= 1'b0;
      end
    end
  end

  assign ex.ex_valid     = ex_valid_r;
  assign ex.ex_pc        = id_ex_r.pc;
  assign ex.ex_rs1_val   = id_ex_r.rs1_val;
  assign ex.ex_rs2_val   = id_ex_r.rs2_val;
  assign ex.ex_imm       = id_ex_r.imm;
  assign ex.ex_rd        = id_ex_r.rd;
  assign ex.ex_funct3    = id_ex_r.funct3;
  assign ex.ex_alu_op    = id_ex_r.alu_op;
  assign ex.ex_op_type   = id_ex_r.op_type;
  assign ex.ex_reg_write = id_ex_r.reg_write;
  assign ex.ex_mem_read  = id_ex_r.mem_read;
  assign ex.ex_mem_write = id_ex_r.mem_write;
  assign ex.ex_illegal   = id_ex_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions, expected ID/EX records queued.
module tb_decode_stage;
  import risc_v_32i::*;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_read;
  logic [31:0] rs2_read;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  int tests;
  int fails;
  id_ex_t exp_q[$];

  decode_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  decode_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .id_ready (id_ready),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_read (rs1_read),
    .rs2_read (rs2_read),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flush    (flush),
    .ex       (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic id_ex_t mk(input logic [31:0] pc, r1, r2, imm, input logic [4:0] rd,
                                input logic [2:0] f3, input alu_op_t op, input op_type_t ot,
                                input logic rw, mr, mw, ill);
    id_ex_t e;
    e = '{pc: pc, rs1_val: r1, rs2_val: r2, imm: imm, rd: rd, funct3: f3, alu_op: op,
          op_type: ot, reg_write: rw, mem_read: mr, mem_write: mw, illegal: ill};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, pc, r1, r2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic fl, er);
    if_valid    = v;
    if_instr    = ins;
    if_pc       = pc;
    rs1_read    = r1;
    rs2_read    = r2;
    wb_we       = we;
    wb_addr     = wa;
    wb_data     = wd;
    flush       = fl;
    bus.ex_ready = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every accepted ID/EX transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      id_ex_t act;
      id_ex_t exp;
      act = '{pc: bus.ex_pc, rs1_val: bus.ex_rs1_val, rs2_val: bus.ex_rs2_val,
              imm: bus.ex_imm, rd: bus.ex_rd, funct3: bus.ex_funct3, alu_op: bus.ex_alu_op,
              op_type: bus.ex_op_type, reg_write: bus.ex_reg_write,
              mem_read: bus.ex_mem_read, mem_write: bus.ex_mem_write,
              illegal: bus.ex_illegal};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %h expected nothing", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL out_pc%h: got %h expected %h", exp.pc, act, exp);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_rd", {27'd0, bus.ex_rd}, 32'd0);
    chk("rst_imm", bus.ex_imm, 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1 chk("addi_ready", {31'd0, id_ready}, 32'd1);
    exp_q.push_back(mk(32'h100, 32'h0, 32'h0, 32'd5, 5'd1, 3'd0, ADD, OPT_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // sub x3,x1,x2 plain, rs1 bypass, rs2 bypass
    drive(1'b1, 32'h402081B3, 32'h104, 32'd10, 32'd3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1 chk("rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("rs2_addr", {27'd0, rs2_addr}, 32'd2);
    exp_q.push_back(mk(32'h104, 32'd10, 32'd3, 32'd0, 5'd3, 3'd0, SUB, OPT_OP, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'h402081B3, 32'h108, 32'd10, 32'd3, 1'b1, 5'd1, 32'd99, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h108, 32'd99, 32'd3, 32'd0, 5'd3, 3'd0, SUB, OPT_OP, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'h402081B3, 32'h10C, 32'd10, 32'd3, 1'b1, 5'd2, 32'd55, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h10C, 32'd10, 32'd55, 32'd0, 5'd3, 3'd0, SUB, OPT_OP, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // writeback to x0 must not bypass onto an x0 source
    drive(1'b1, 32'h00500093, 32'h110, 32'h1234, 32'h0, 1'b1, 5'd0, 32'd99, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h110, 32'h1234, 32'h0, 32'd5, 5'd1, 3'd0, ADD, OPT_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // lw x5,0(x1) then add x6,x5,x5: one bubble
    drive(1'b1, 32'h0000A283, 32'h114, 32'h200, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h114, 32'h200, 32'h0, 32'd0, 5'd5, 3'd2, ADD, OPT_LOAD, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'h00528333, 32'h118, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1 chk("hazard_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("post_bubble_ready", {31'd0, id_ready}, 32'd1);
    exp_q.push_back(mk(32'h118, 32'h11, 32'h22, 32'd0, 5'd6, 3'd0, ADD, OPT_OP, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h11C, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h11C, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd29, 3'd0, ADD, OPT_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    // unknown opcode 0x7F
    drive(1'b1, 32'h0000037F, 32'h120, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h120, 32'h0, 32'h0, 32'd0, 5'd6, 3'd0, ADD, OPT_ILLEGAL, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    // execute stalls: hold, and flush is ignored while stalled
    drive(1'b1, 32'h123453B7, 32'h124, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 chk("stall_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("hold_pc", bus.ex_pc, 32'h120);
    chk("hold_illegal", {31'd0, bus.ex_illegal}, 32'd1);
    drive(1'b1, 32'h123453B7, 32'h124, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("stall_flush_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("stall_flush_pc", bus.ex_pc, 32'h120);
    // lui x7,0x12345 accepted once execute resumes
    drive(1'b1, 32'h123453B7, 32'h124, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h124, 32'h0, 32'h0, 32'h12345000, 5'd7, 3'd5, ADD, OPT_LUI, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // flush consumes and drops jal
    drive(1'b1, 32'h008000EF, 32'h128, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    #1 chk("flush_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    drive(1'b1, 32'h008000EF, 32'h128, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h128, 32'h0, 32'h0, 32'd8, 5'd1, 3'd0, ADD, OPT_JAL, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    // srai x2,x1,3 / addi x2,x1,-1024 / sw x2,8(x1)
    drive(1'b1, 32'h4030D113, 32'h12C, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h12C, 32'h80000000, 32'h0, 32'h403, 5'd2, 3'd5, SRA, OPT_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'hC0008113, 32'h130, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h130, 32'h0, 32'h0, 32'hFFFFFC00, 5'd2, 3'd0, ADD, OPT_OP_IMM, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    drive(1'b1, 32'h0020A423, 32'h134, 32'h40, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    exp_q.push_back(mk(32'h134, 32'h40, 32'h55, 32'd8, 5'd8, 3'd2, ADD, OPT_STORE, 1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    // idle fetch
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("idle_valid", {31'd0, bus.ex_valid}, 32'd0);
    // asynchronous reset mid-stream
    drive(1'b1, 32'h00500093, 32'h138, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 chk("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("async_rst_pc", bus.ex_pc, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage of the RV32I pipeline; sits directly upstream of `registers`.
- Drives the register-file read addresses and captures the read data into the ID/EX pipeline register.
- Decodes opcode, immediate and ALU control, detects load-use hazards, and bypasses the same-cycle writeback.
- Valid/ready handshake toward fetch (upstream) and execute (downstream).

Parameters:
- XLEN, 32, datapath and instruction width (equals REG_SIZE)
- RA_W, 5, register address width (equals REG_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch holds an instruction
- if_instr  in  XLEN  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  decode accepts if_instr this cycle
- rs1_addr  out  RA_W  register-file read port 1 address (instr[19:15])
- rs2_addr  out  RA_W  register-file read port 2 address (instr[24:20])
- rs1_read  in  XLEN  register-file read data 1
- rs2_read  in  XLEN  register-file read data 2
- wb_we  in  1  writeback write enable (same net as regfile write_enable)
- wb_addr  in  RA_W  writeback address
- wb_data  in  XLEN  writeback data
- flush  in  1  EX redirect; kill the instruction in decode
- ex_ready  in  1  execute accepts ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  registered operands
- ex_rd  out  RA_W  destination register
- ex_funct3  out  3  funct3 passthrough
- ex_alu_op  out  4  alu_op_t
- ex_op_type  out  4  op_type_t
- ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal  out  1  control flags

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0. id_ready is combinational and not reset.
- Read path: rs1_addr/rs2_addr are combinational from if_instr. Operand = wb_data when wb_we && wb_addr==rsX_addr && wb_addr!=0; otherwise rsX_read.
- load_en = !ex_valid || ex_ready.
- Hazard: ex_valid && ex_mem_read && ex_rd!=0 && ex_rd matches a *used* source.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP only.
- id_ready = load_en && (!hazard || flush).
- Priority on each clk edge where load_en=1:
  - flush → ex_valid←0.
  - else hazard → ex_valid←0 (one bubble); the instruction is held in fetch.
  - else if_valid → capture all fields, ex_valid←1.
  - else ex_valid←0.
- When load_en=0, ID/EX holds all fields, and flush is ignored until load_en=1.
- When flush=1 and if_valid=1, id_ready=1: the instruction is consumed and dropped.
- Latency: one cycle from accept to ex_valid.
- Immediates (sign-extended from instr[31]):
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits zero.
  - J: JAL, bit0=0.
  - OP, FENCE, SYSTEM: imm=0.
- ALU op:
  - OP: funct3 selects the op; funct7[5] selects SUB/SRA.
  - OP-IMM: funct3 selects the op; instr[30] selects SRAI only.
  - All other opcodes: ADD.
- reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd!=0; 0 otherwise.
- mem_read=LOAD; mem_write=STORE.
- Unknown opcode: ex_illegal=1, reg_write/mem_read/mem_write=0, op_type=OPT_ILLEGAL. The instruction still flows through with ex_valid=1.
- A mid-operation reset clears ex_valid immediately.

Decomposition:
- Package risc_v_32i gains:
  - opcode constants (OPC_LUI…OPC_SYSTEM);
  - typedef enum logic[3:0] alu_op_t {ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND};
  - typedef enum logic[3:0] op_type_t;
  - typedef struct id_ex_t for the pipeline register.
- One sub-module: imm_gen (combinational immediate generator, instr→imm).

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) with ex_ready=1 → next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_op=ADD, ex_reg_write=1.
- `sub x3,x1,x2` (0x402081B3), rs1_read=10, rs2_read=3 → ex_alu_op=SUB, ex_rs1_val=10, ex_rs2_val=3. Same instruction with wb_we=1, wb_addr=1, wb_data=99 → ex_rs1_val=99. With wb_addr=0 → rs1_read is used.
- `lw x5,0(x1)` (0x0000A283) then `add x6,x5,x5` (0x00528333) → one cycle with id_ready=0 and a bubble (ex_valid=0); the add is captured the following cycle.
- `beq x0,x0,-4` (0xFE000EE3) → ex_imm=0xFFFFFFFC, ex_reg_write=0. Opcode 0x7F → ex_illegal=1, ex_reg_write=0.
- ex_ready=0 with ex_valid=1 → id_ready=0 and ID/EX holds. flush=1 with if_valid=1 and load_en=1 → id_ready=1 and next ex_valid=0. rst_n pulled low mid-stream → ex_valid=0 asynchronously.
